// File: rtl/upc_checkout_lane.sv
// Checkout lane: accepts scanned UPC codes over valid/ready, classifies them through lookup masks,
// holds each verdict for HOLD_CYCLES, keeps saturating item/theft counts and raises a sticky theft alarm.
module upc_checkout_lane #(
    parameter int unsigned          CODE_W       = 3,
    parameter logic [2**CODE_W-1:0] SALE_MASK    = 8'hEC,
    parameter logic [2**CODE_W-1:0] PRICEY_MASK  = 8'h31,
    parameter int unsigned          COUNT_W      = 8,
    parameter int unsigned          HOLD_CYCLES  = 4,
    parameter int unsigned          ALARM_THRESH = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               scan_valid,
    output logic               scan_ready,
    input  logic [CODE_W-1:0]  scan_code,
    input  logic               scan_mark,
    input  logic               clear_counts,
    input  logic               alarm_ack,
    output logic               result_valid,
    output logic               sale,
    output logic               stolen,
    output logic [COUNT_W-1:0] item_count,
    output logic [COUNT_W-1:0] stolen_count,
    output logic               alarm
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [COUNT_W-1:0] THRESH    = COUNT_W'(ALARM_THRESH);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        ALARM
    } state_t;

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               accept;
    logic               stolen_v;
    logic [COUNT_W-1:0] item_base;
    logic [COUNT_W-1:0] item_inc;
    logic [COUNT_W-1:0] stolen_inc;

    assign scan_ready = (state == IDLE);

    always_comb begin
        accept   = scan_valid & scan_ready;
        stolen_v = PRICEY_MASK[scan_code] & ~scan_mark;
        // Clear is applied before the increment so a clear+accept edge lands on 1.
        item_base = clear_counts ? '0 : item_count;
        item_inc  = item_base;
        if (item_base != '1)
            item_inc = item_base + COUNT_W'(1);
        stolen_inc = stolen_count;
        if (stolen_v && (stolen_count != '1))
            stolen_inc = stolen_count + COUNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            result_valid <= 1'b0;
            sale         <= 1'b0;
            stolen       <= 1'b0;
            item_count   <= '0;
            stolen_count <= '0;
            alarm        <= 1'b0;
        end else begin
            if (accept)
                item_count <= item_inc;
            else if (clear_counts)
                item_count <= '0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= SHOW;
                        hold_cnt     <= HOLD_LOAD;
                        result_valid <= 1'b1;
                        sale         <= SALE_MASK[scan_code];
                        stolen       <= stolen_v;
                        stolen_count <= stolen_inc;
                        if (stolen_inc >= THRESH)
                            alarm <= 1'b1;
                    end
                end
                SHOW: begin
                    if (hold_cnt == '0) begin
                        result_valid <= 1'b0;
                        state        <= alarm ? ALARM : IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                ALARM: begin
                    if (alarm_ack) begin
                        state        <= IDLE;
                        alarm        <= 1'b0;
                        stolen_count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_upc_checkout_lane.sv
// Directed scoreboard bench for upc_checkout_lane: expected verdicts and counts are queued on each
// driven scan and compared when result_valid shows the verdict.
module tb_upc_checkout_lane;

    logic       clk;
    logic       reset_n;
    logic       scan_valid;
    logic       scan_ready;
    logic [2:0] scan_code;
    logic       scan_mark;
    logic       clear_counts;
    logic       alarm_ack;
    logic       result_valid;
    logic       sale;
    logic       stolen;
    logic [7:0] item_count;
    logic [7:0] stolen_count;
    logic       alarm;

    upc_checkout_lane #(
        .CODE_W      (3),
        .SALE_MASK   (8'hEC),
        .PRICEY_MASK (8'h31),
        .COUNT_W     (8),
        .HOLD_CYCLES (4),
        .ALARM_THRESH(3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .scan_valid  (scan_valid),
        .scan_ready  (scan_ready),
        .scan_code   (scan_code),
        .scan_mark   (scan_mark),
        .clear_counts(clear_counts),
        .alarm_ack   (alarm_ack),
        .result_valid(result_valid),
        .sale        (sale),
        .stolen      (stolen),
        .item_count  (item_count),
        .stolen_count(stolen_count),
        .alarm       (alarm)
    );

    typedef struct packed {
        logic       sale;
        logic       stolen;
        logic [7:0] items;
        logic [7:0] stolen_cnt;
        logic       alarm;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int   m_item   = 0;
    int   m_stolen = 0;
    logic m_alarm  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_alarm();
        check("alarm_state_rv", {31'd0, result_valid}, 32'd0);
        check("alarm_state_ready", {31'd0, scan_ready}, 32'd0);
        check("alarm_state_alarm", {31'd0, alarm}, 32'd1);
        scan_valid = 1'b1;
        scan_code  = 3'd2;
        scan_mark  = 1'b1;
        repeat (2) begin
            step();
            check("alarm_ignore_rv", {31'd0, result_valid}, 32'd0);
            check("alarm_ignore_items", {24'd0, item_count}, 32'(m_item));
        end
        scan_valid = 1'b0;
        alarm_ack  = 1'b1;
        step();
        alarm_ack = 1'b0;
        m_stolen  = 0;
        m_alarm   = 1'b0;
        check("ack_alarm", {31'd0, alarm}, 32'd0);
        check("ack_stolen_cnt", {24'd0, stolen_count}, 32'd0);
        check("ack_ready", {31'd0, scan_ready}, 32'd1);
        check("ack_items", {24'd0, item_count}, 32'(m_item));
    endtask

    // Caller guarantees the lane is idle and time is just after an active edge.
    task automatic scan(input logic [2:0] code, input logic mark, input logic clr, input logic keep);
        logic u, p, c;
        exp_t e, got;
        u = code[2];
        p = code[1];
        c = code[0];
        e.sale   = p | (u & c);
        e.stolen = ~p & (u | ~c) & ~mark;
        if (clr) m_item = 1;
        else if (m_item != 255) m_item++;
        if (e.stolen && m_stolen != 255) m_stolen++;
        if (m_stolen >= 3) m_alarm = 1'b1;
        e.items      = 8'(m_item);
        e.stolen_cnt = 8'(m_stolen);
        e.alarm      = m_alarm;
        sb.push_back(e);

        check("pre_ready", {31'd0, scan_ready}, 32'd1);
        scan_valid   = 1'b1;
        scan_code    = code;
        scan_mark    = mark;
        clear_counts = clr;
        step();
        if (!keep) scan_valid = 1'b0;
        clear_counts = 1'b0;

        check("latency_rv", {31'd0, result_valid}, 32'd1);
        if (result_valid && sb.size() > 0) begin
            got = sb.pop_front();
            check("sale", {31'd0, sale}, {31'd0, got.sale});
            check("stolen", {31'd0, stolen}, {31'd0, got.stolen});
            check("item_count", {24'd0, item_count}, {24'd0, got.items});
            check("stolen_count", {24'd0, stolen_count}, {24'd0, got.stolen_cnt});
            check("alarm", {31'd0, alarm}, {31'd0, got.alarm});
        end else begin
            void'(sb.pop_front());
        end
        check("hold_ready", {31'd0, scan_ready}, 32'd0);
        repeat (3) begin
            step();
            check("hold_rv", {31'd0, result_valid}, 32'd1);
            check("hold_ready", {31'd0, scan_ready}, 32'd0);
            check("hold_items", {24'd0, item_count}, 32'(m_item));
        end
        step();
        scan_valid = 1'b0;
        check("end_rv", {31'd0, result_valid}, 32'd0);
        check("end_ready", {31'd0, scan_ready}, {31'd0, ~m_alarm});
        check("end_sale_held", {31'd0, sale}, {31'd0, e.sale});
        check("end_stolen_held", {31'd0, stolen}, {31'd0, e.stolen});
        check("end_items", {24'd0, item_count}, 32'(m_item));
        if (m_alarm) ack_alarm();
    endtask

    initial begin
        reset_n      = 1'b0;
        scan_valid   = 1'b1;
        scan_code    = 3'd5;
        scan_mark    = 1'b0;
        clear_counts = 1'b0;
        alarm_ack    = 1'b0;

        // T1: reset with scan_valid asserted
        step();
        step();
        check("t1_ready", {31'd0, scan_ready}, 32'd1);
        check("t1_rv", {31'd0, result_valid}, 32'd0);
        check("t1_sale", {31'd0, sale}, 32'd0);
        check("t1_stolen", {31'd0, stolen}, 32'd0);
        check("t1_items", {24'd0, item_count}, 32'd0);
        check("t1_stolen_cnt", {24'd0, stolen_count}, 32'd0);
        check("t1_alarm", {31'd0, alarm}, 32'd0);
        scan_valid = 1'b0;
        reset_n    = 1'b1;

        // T2: every code with and without mark (third unmarked theft trips the alarm)
        for (int i = 0; i < 8; i++) begin
            scan(3'(i), 1'b0, 1'b0, 1'b0);
            scan(3'(i), 1'b1, 1'b0, 1'b0);
        end

        // T3: scan_valid held high through the hold must not re-accept
        scan(3'd2, 1'b1, 1'b0, 1'b1);
        step();
        check("t3_no_reaccept_rv", {31'd0, result_valid}, 32'd0);
        check("t3_no_reaccept_items", {24'd0, item_count}, 32'(m_item));

        // T4: three thefts from a clean reset, with an ignored ack in between
        reset_n = 1'b0;
        step();
        reset_n  = 1'b1;
        m_item   = 0;
        m_stolen = 0;
        m_alarm  = 1'b0;
        scan(3'd0, 1'b0, 1'b0, 1'b0);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check("t4_ack_ignored", {24'd0, stolen_count}, 32'd1);
        scan(3'd0, 1'b0, 1'b0, 1'b0);
        check("t4_no_alarm_yet", {31'd0, alarm}, 32'd0);
        scan(3'd0, 1'b0, 1'b0, 1'b0);

        // T5: item counter saturation, then clear with and without accept
        for (int i = 0; i < 300; i++) scan(3'd2, 1'b1, 1'b0, 1'b0);
        check("t5_saturated", {24'd0, item_count}, 32'd255);
        scan(3'd2, 1'b1, 1'b1, 1'b0);
        check("t5_clear_accept", {24'd0, item_count}, 32'd1);
        clear_counts = 1'b1;
        step();
        clear_counts = 1'b0;
        m_item = 0;
        check("t5_clear_idle", {24'd0, item_count}, 32'd0);

        // T6: reset in the middle of a hold
        scan_valid = 1'b1;
        scan_code  = 3'd5;
        scan_mark  = 1'b0;
        step();
        scan_valid = 1'b0;
        check("t6_rv_before", {31'd0, result_valid}, 32'd1);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("t6_rv", {31'd0, result_valid}, 32'd0);
        check("t6_ready", {31'd0, scan_ready}, 32'd1);
        check("t6_items", {24'd0, item_count}, 32'd0);
        check("t6_stolen_cnt", {24'd0, stolen_count}, 32'd0);
        check("t6_sale", {31'd0, sale}, 32'd0);
        check("t6_stolen", {31'd0, stolen}, 32'd0);
        m_item   = 0;
        m_stolen = 0;
        m_alarm  = 1'b0;
        scan(3'd7, 1'b0, 1'b0, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
